// File: rtl/spi_sck_ctrl.sv
// spi_sck_ctrl: SPI master timing engine generating SCK, chip selects and sample/shift strobes.
module spi_sck_ctrl #(
   parameter int WIDTH_LOG = 5,
   parameter int DIV_WIDTH = 8,
   parameter int CS_NUM    = 4,
   parameter int CS_SEL_W  = 2,
   parameter int DLY_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 cpol,
   input  logic                 cpha,
   input  logic [DIV_WIDTH-1:0] clk_div,
   input  logic [WIDTH_LOG-1:0] spi_width,
   input  logic [CS_SEL_W-1:0]  cs_sel,
   input  logic [DLY_WIDTH-1:0] cs_dly,
   output logic                 busy,
   output logic                 sck,
   output logic [CS_NUM-1:0]    cs_n,
   output logic                 sample_edge,
   output logic                 shift_edge,
   output logic [WIDTH_LOG-1:0] bit_cnt,
   output logic                 done
);
   localparam int CW = DIV_WIDTH > DLY_WIDTH ? DIV_WIDTH : DLY_WIDTH;
   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
   state_t               state_q;
   logic                 cpol_q, cpha_q, sck_q, busy_q, done_q, sample_q, shift_q;
   logic [DIV_WIDTH-1:0] div_q;
   logic [WIDTH_LOG-1:0] spw_q, bit_cnt_q;
   logic [DLY_WIDTH-1:0] dly_q;
   logic [CW-1:0]        cnt_q;
   logic [WIDTH_LOG:0]   tgl_q;
   logic [CS_NUM-1:0]    cs_n_q, sel_n;
   logic                 dly_end, div_end, lead;
   always_comb begin
      sel_n = '1;
      for (int k = 0; k < CS_NUM; k++)
         if (cs_sel == CS_SEL_W'(k)) sel_n[k] = 1'b0;
      dly_end = cnt_q == CW'(dly_q);
      div_end = cnt_q == CW'(div_q);
      lead    = ~tgl_q[0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         div_q     <= '0;
         spw_q     <= '0;
         dly_q     <= '0;
         cnt_q     <= '0;
         tgl_q     <= '0;
         sck_q     <= cpol;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sample_q  <= 1'b0;
         shift_q   <= 1'b0;
         bit_cnt_q <= '0;
         cs_n_q    <= '1;
      end else begin
         done_q   <= 1'b0;
         sample_q <= 1'b0;
         shift_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               sck_q <= cpol;
               if (start) begin
                  state_q <= SETUP;
                  cpol_q  <= cpol;
                  cpha_q  <= cpha;
                  div_q   <= clk_div;
                  spw_q   <= spi_width;
                  dly_q   <= cs_dly;
                  cnt_q   <= '0;
                  tgl_q   <= '0;
                  cs_n_q  <= sel_n;
                  busy_q  <= 1'b1;
               end
            end
            SETUP: begin
               cnt_q <= dly_end ? '0 : cnt_q + CW'(1);
               if (dly_end) state_q <= XFER;
            end
            XFER: begin
               cnt_q <= div_end ? '0 : cnt_q + CW'(1);
               if (div_end) begin
                  // odd toggles leave cpol (leading), even ones return (trailing)
                  sck_q    <= ~sck_q;
                  tgl_q    <= tgl_q + (WIDTH_LOG+1)'(1);
                  sample_q <= lead ^ cpha_q;
                  shift_q  <= ~(lead ^ cpha_q);
                  if (!lead) bit_cnt_q <= bit_cnt_q + WIDTH_LOG'(1);
                  if (tgl_q == {spw_q, 1'b1}) state_q <= HOLD;
               end
            end
            HOLD: begin
               cnt_q <= dly_end ? '0 : cnt_q + CW'(1);
               if (dly_end) begin
                  state_q   <= IDLE;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  cs_n_q    <= '1;
                  bit_cnt_q <= '0;
               end
            end
         endcase
      end
   end
   assign busy        = busy_q;
   assign sck         = sck_q;
   assign cs_n        = cs_n_q;
   assign sample_edge = sample_q;
   assign shift_edge  = shift_q;
   assign bit_cnt     = bit_cnt_q;
   assign done        = done_q;
endmodule

// File: tb/tb_spi_sck_ctrl.sv
// tb_spi_sck_ctrl: directed and random transfers checked against a cycle-formula model.
module tb_spi_sck_ctrl;
   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
   logic [7:0] clk_div = '0;
   logic [4:0] spi_width = '0;
   logic [2:0] cs_sel = '0;
   logic [3:0] cs_dly = '0;
   logic       busy, sck, sample_edge, shift_edge, done;
   logic [3:0] cs_n;
   logic [4:0] bit_cnt;
   int         checks = 0, errors = 0, cur_t = 0;

   typedef struct {bit cpol; bit cpha; int div; int spw; int sel; int dly;} cfg_t;

   spi_sck_ctrl #(.WIDTH_LOG(5), .DIV_WIDTH(8), .CS_NUM(4), .CS_SEL_W(3), .DLY_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
      .spi_width(spi_width), .cs_sel(cs_sel), .cs_dly(cs_dly), .busy(busy), .sck(sck),
      .cs_n(cs_n), .sample_edge(sample_edge), .shift_edge(shift_edge), .bit_cnt(bit_cnt), .done(done));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed %0h expected %0h", tag, cur_t, obs, exp);
      end
   endtask

   function automatic cfg_t mk(bit p, bit h, int dv, int w, int s, int d);
      cfg_t c;
      c.cpol = p; c.cpha = h; c.div = dv; c.spw = w; c.sel = s; c.dly = d;
      return c;
   endfunction

   function automatic cfg_t rnd();
      return mk(1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 31),
                $urandom_range(0, 7), $urandom_range(0, 15));
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cs"}, cs_n, 4'hF);
      chk({tag, "_sck"}, sck, cpol);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_bit"}, bit_cnt, 0);
      chk({tag, "_strb"}, {sample_edge, shift_edge}, 0);
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      repeat (n) begin
         @(negedge clk);
         cur_t = -1;
         chk_idle("idle");
         cpol = 1'($urandom);
      end
   endtask

   // called just after a negedge: start is sampled on the following posedge (cycle 0)
   task automatic go(input cfg_t c);
      cpol = c.cpol; cpha = c.cpha; clk_div = 8'(c.div); spi_width = 5'(c.spw);
      cs_sel = 3'(c.sel); cs_dly = 4'(c.dly); start = 1'b1;
      @(posedge clk);
   endtask

   // expected outputs derived from phase boundaries: SETUP su, then 2n half-periods of h, HOLD su
   task automatic run(input cfg_t c, input bit junk, input int lim);
      int su, h, n, tt, x, k, last;
      bit strb, lead;
      logic [3:0] mask;
      su = c.dly + 1; h = c.div + 1; n = c.spw + 1;
      tt = 2 * su + 2 * n * h + 1;
      last = (lim > 0) ? lim : tt;
      mask = (c.sel < 4) ? ~(4'b1 << c.sel) : 4'hF;
      for (int t = 1; t <= last; t++) begin
         @(negedge clk);
         cur_t = t;
         x = t - 1 - su;
         k = (x < 0) ? 0 : ((x / h > 2 * n) ? 2 * n : x / h);
         strb = (x > 0) && (x % h == 0) && (x / h <= 2 * n);
         lead = k[0];
         if (t == tt) begin
            chk("end_busy", busy, 0);
            chk("end_cs", cs_n, 4'hF);
            chk("end_done", done, 1);
            chk("end_bit", bit_cnt, 0);
            chk("end_sck", sck, c.cpol);
            chk("end_strb", {sample_edge, shift_edge}, 0);
         end else begin
            chk("busy", busy, 1);
            chk("cs", cs_n, mask);
            chk("done", done, 0);
            chk("bit", bit_cnt, (k / 2) % 32);
            chk("sck", sck, c.cpol ^ k[0]);
            chk("sample", sample_edge, strb && (lead != c.cpha));
            chk("shift", shift_edge, strb && (lead == c.cpha));
         end
         if (t == tt) begin
            start = 1'b0; cpol = c.cpol;
         end else if (junk) begin
            start = 1'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
            clk_div = 8'($urandom); spi_width = 5'($urandom); cs_sel = 3'($urandom);
            cs_dly = 4'($urandom);
         end else start = 1'b0;
      end
   endtask

   initial begin
      cfg_t c;
      cpol = 1'b1;
      repeat (2) @(negedge clk);
      cur_t = 0;
      chk_idle("reset");
      rst = 1'b0;
      idle(3);
      for (int m = 0; m < 4; m++) begin
         go(mk(m[1], m[0], 1, 7, 2, 0));
         run(mk(m[1], m[0], 1, 7, 2, 0), 0, 0);
         idle(2);
      end
      go(mk(0, 0, 0, 0, 0, 3));
      run(mk(0, 0, 0, 0, 0, 3), 0, 0);
      go(mk(1, 0, 0, 0, 1, 3));
      run(mk(1, 0, 0, 0, 1, 3), 0, 0);
      idle(2);
      go(mk(0, 0, 1, 7, 5, 0));
      run(mk(0, 0, 1, 7, 5, 0), 1, 0);
      idle(2);
      go(mk(1, 1, 0, 31, 3, 1));
      run(mk(1, 1, 0, 31, 3, 1), 0, 0);
      idle(1);
      for (int i = 0; i < 25; i++) begin
         c = rnd();
         go(c);
         run(c, 1'($urandom), 0);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      go(mk(0, 0, 1, 7, 2, 0));
      run(mk(0, 0, 1, 7, 2, 0), 0, 9);
      rst = 1'b1;
      @(negedge clk);
      cur_t = 10;
      chk_idle("rst_mid");
      rst = 1'b0;
      idle(40);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
